// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority from channel 0, or a
// wrapping upward scan starting at a round-robin pointer.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [GW-1:0]     start,
    input  logic              mode,
    output logic [GW-1:0]     winner,
    output logic              valid
);

    int base;
    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        base   = mode ? int'(start) : 0;
        if (base >= NUM_CH) begin
            base = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            idx = base + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!valid && req[idx]) begin
                winner = GW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter onto a single-transaction memory port; the winning
// request is latched for the whole transaction and load data is registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int MODE   = 0,
    parameter  int AW     = 32,
    parameter  int DW     = 32,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SW     = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_access,
    input  logic [NUM_CH-1:0]    req_write,
    input  logic [NUM_CH*AW-1:0] req_addr,
    input  logic [NUM_CH*2-1:0]  req_size,
    input  logic [NUM_CH*SW-1:0] req_sel,
    input  logic [NUM_CH*DW-1:0] req_wdata,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [DW-1:0]        req_rdata,
    output logic                 mem_access,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_a,
    output logic [1:0]           mem_size,
    output logic [SW-1:0]        mem_sel,
    output logic [DW-1:0]        mem_st_data,
    input  logic                 mem_ready,
    input  logic [DW-1:0]        mem_data,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam logic RR_MODE = (MODE == ARB_RR);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   winner;
    logic            win_valid;
    logic [DW-1:0]   rdata;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req    (req_access),
        .start  (ptr),
        .mode   (RR_MODE),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (win_valid) state_next = ARB_BUSY;
            ARB_BUSY: if (mem_ready) state_next = ARB_DONE;
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Request latch, completion capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_access  <= 1'b0;
            mem_write   <= 1'b0;
            mem_a       <= '0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
            grant_id    <= '0;
            rdata       <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_valid) begin
                        mem_access  <= 1'b1;
                        mem_write   <= req_write[winner];
                        mem_a       <= req_addr[int'(winner)*AW +: AW];
                        mem_size    <= req_size[int'(winner)*2 +: 2];
                        mem_sel     <= req_sel[int'(winner)*SW +: SW];
                        mem_st_data <= req_wdata[int'(winner)*DW +: DW];
                        grant_id    <= winner;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready) begin
                        rdata      <= mem_data;
                        mem_access <= 1'b0;
                    end
                end
                ARB_DONE: begin
                    if (int'(grant_id) >= NUM_CH - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_id + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ARB_DONE) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy      = (state != ARB_IDLE);
    assign req_rdata = rdata;

endmodule
